// File: rtl/lms_ctr_gpio_bidir_pkg.sv
// lms_ctr_gpio_pkg
//   Shared constants for the lms_ctr bidirectional GPIO block:
//   Avalon word addresses of the register map and the encodings of the
//   EDGE_TYPE parameter.
package lms_ctr_gpio_pkg;

   // Register map (Avalon word addresses). Addresses 6 and 7 are unmapped.
   localparam logic [2:0] ADDR_DATA = 3'd0;
   localparam logic [2:0] ADDR_DIR  = 3'd1;
   localparam logic [2:0] ADDR_MASK = 3'd2;
   localparam logic [2:0] ADDR_EDGE = 3'd3;
   localparam logic [2:0] ADDR_SET  = 3'd4;
   localparam logic [2:0] ADDR_CLR  = 3'd5;

   // Edge-capture selection.
   localparam int unsigned EDGE_RISE = 0;
   localparam int unsigned EDGE_FALL = 1;
   localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/lms_ctr_gpio_bidir_if.sv
// lms_ctr_gpio_bidir_if
//   Avalon-MM slave bus bundle for the GPIO block.
//   address    : word address (3 bits)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   read_n     : active-low read strobe
//   writedata  : 32-bit write data
//   readdata   : 32-bit registered read data (readLatency = 1)
interface lms_ctr_gpio_bidir_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic        read_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, read_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, read_n, writedata,
      output readdata
   );
endinterface

// File: rtl/lms_ctr_gpio_bidir_sync_edge.sv
// gpio_sync_edge
//   Vector-wide input synchroniser, previous-sample register and edge
//   detector for the GPIO pins.
//   clk, reset_n : clock, asynchronous active-low reset
//   in_port      : asynchronous pin inputs
//   in_sync      : synchronised pin values (SYNC_STAGES flops deep)
//   edge_pulse   : one-cycle pulse per bit on the edge chosen by EDGE_TYPE
module gpio_sync_edge
   import lms_ctr_gpio_pkg::*;
#(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned EDGE_TYPE   = EDGE_RISE
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] in_sync,
   output logic [WIDTH-1:0] edge_pulse
);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_d [SYNC_STAGES];
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] prev_d;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;

   always_comb begin
      sync_d[0] = in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
      prev_d = sync_q[SYNC_STAGES-1];
   end

   // NOTE: the synchroniser array is an ordinary flop chain, not a memory,
   // so every stage is reset; otherwise a spurious edge could be detected
   // in the first cycles after reset release.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         prev_q <= '0;
      end else begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_d[i];
         end
         prev_q <= prev_d;
      end
   end

   assign in_sync    = sync_q[SYNC_STAGES-1];
   assign rise       = in_sync & ~prev_q;
   assign fall       = ~in_sync & prev_q;
   assign edge_pulse = (EDGE_TYPE == EDGE_RISE) ? rise :
                       (EDGE_TYPE == EDGE_FALL) ? fall : (rise | fall);

endmodule

// File: rtl/lms_ctr_gpio_bidir.sv
// lms_ctr_gpio_bidir
//   Parametrised bidirectional GPIO on the lms_ctr Avalon-MM bus: data,
//   direction, interrupt-mask and edge-capture registers, atomic set/clear
//   of the output register, synchronised inputs and a level IRQ.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : Avalon-MM slave (address/chipselect/write_n/read_n/
//                  writedata in, registered readdata out)
//   in_port      : asynchronous pin inputs
//   out_port     : output data register
//   oe_port      : output enable (direction register, 1 = output)
//   irq          : OR of (edge_capture & irq_mask)
module lms_ctr_gpio_bidir
   import lms_ctr_gpio_pkg::*;
#(
   parameter int unsigned      WIDTH       = 4,
   parameter logic [WIDTH-1:0] OUT_RESET   = WIDTH'(3),
   parameter logic [WIDTH-1:0] DIR_RESET   = '1,
   parameter int unsigned      EDGE_TYPE   = EDGE_RISE,
   parameter int unsigned      SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   lms_ctr_gpio_bidir_if.slave        bus,
   input  logic [WIDTH-1:0]           in_port,
   output logic [WIDTH-1:0]           out_port,
   output logic [WIDTH-1:0]           oe_port,
   output logic                       irq
);

   logic             wr;
   logic             rd;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] in_sync;
   logic [WIDTH-1:0] edge_pulse;

   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic [WIDTH-1:0] dir_q,      dir_d;
   logic [WIDTH-1:0] mask_q,     mask_d;
   logic [WIDTH-1:0] edge_q,     edge_d;
   logic [31:0]      readdata_q, readdata_d;
   logic [31:0]      rd_val;

   // Upper writedata bits are architecturally ignored.
   logic             unused_wd;
   assign unused_wd = ^bus.writedata;

   assign wr = bus.chipselect & ~bus.write_n;
   assign rd = bus.chipselect & ~bus.read_n;
   assign wd = bus.writedata[WIDTH-1:0];

   gpio_sync_edge #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_TYPE   (EDGE_TYPE)
   ) u_sync_edge (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_port    (in_port),
      .in_sync    (in_sync),
      .edge_pulse (edge_pulse)
   );

   // Register-file write path.
   // NOTE: every variable gets its hold value first so no path through the
   // case leaves it unassigned, which would infer a latch.
   always_comb begin
      data_out_d = data_out_q;
      dir_d      = dir_q;
      mask_d     = mask_q;
      edge_d     = edge_q;
      if (wr) begin
         case (bus.address)
            ADDR_DATA: data_out_d = wd;
            ADDR_DIR:  dir_d      = wd;
            ADDR_MASK: mask_d     = wd;
            ADDR_EDGE: edge_d     = edge_q & ~wd;
            ADDR_SET:  data_out_d = data_out_q | wd;
            ADDR_CLR:  data_out_d = data_out_q & ~wd;
            default:   ;
         endcase
      end
      // A new edge is OR-ed in after the write-1-clear so it wins a collision.
      edge_d = edge_d | edge_pulse;
   end

   // Read mux works on the pre-write register values; readdata holds
   // between reads.
   always_comb begin
      rd_val = '0;
      case (bus.address)
         ADDR_DATA: rd_val[WIDTH-1:0] = (data_out_q & dir_q) | (in_sync & ~dir_q);
         ADDR_DIR:  rd_val[WIDTH-1:0] = dir_q;
         ADDR_MASK: rd_val[WIDTH-1:0] = mask_q;
         ADDR_EDGE: rd_val[WIDTH-1:0] = edge_q;
         default:   ;
      endcase
      readdata_d = rd ? rd_val : readdata_q;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops
   // sample the same pre-edge values regardless of evaluation order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out_q <= OUT_RESET;
         dir_q      <= DIR_RESET;
         mask_q     <= '0;
         edge_q     <= '0;
         readdata_q <= '0;
      end else begin
         data_out_q <= data_out_d;
         dir_q      <= dir_d;
         mask_q     <= mask_d;
         edge_q     <= edge_d;
         readdata_q <= readdata_d;
      end
   end

   assign bus.readdata = readdata_q;
   assign out_port     = data_out_q;
   assign oe_port      = dir_q;
   assign irq          = |(edge_q & mask_q);

endmodule

// File: tb/tb_lms_ctr_gpio_bidir.sv
// tb_lms_ctr_gpio_bidir
//   Self-checking bench for lms_ctr_gpio_bidir (WIDTH=4, rising edges,
//   two synchroniser stages). A behavioural model tracks the register map
//   and a history of pin samples; a compare process checks every output
//   shortly after each rising clock edge, and directed steps pin the model
//   with hand-computed values.
module tb_lms_ctr_gpio_bidir;
   import lms_ctr_gpio_pkg::*;

   localparam int unsigned      WIDTH       = 4;
   localparam int unsigned      SYNC_STAGES = 2;
   localparam int unsigned      EDGE_TYPE   = EDGE_RISE;
   localparam logic [WIDTH-1:0] OUT_RESET   = 4'h3;
   localparam logic [WIDTH-1:0] DIR_RESET   = 4'hF;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [WIDTH-1:0] in_port = '0;
   logic [WIDTH-1:0] out_port;
   logic [WIDTH-1:0] oe_port;
   logic             irq;

   int checks = 0;
   int errors = 0;

   lms_ctr_gpio_bidir_if bus ();

   lms_ctr_gpio_bidir #(
      .WIDTH       (WIDTH),
      .OUT_RESET   (OUT_RESET),
      .DIR_RESET   (DIR_RESET),
      .EDGE_TYPE   (EDGE_TYPE),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus),
      .in_port  (in_port),
      .out_port (out_port),
      .oe_port  (oe_port),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [WIDTH-1:0] m_out, m_dir, m_mask, m_edge;
   logic [31:0]      m_rdata;
   // m_hist[0] is the newest pin sample; m_hist[SYNC_STAGES-1] is the
   // synchronised value and m_hist[SYNC_STAGES] the one before it.
   logic [WIDTH-1:0] m_hist [SYNC_STAGES+1];

   function automatic logic [31:0] model_read(input logic [2:0] a, input logic [WIDTH-1:0] s);
      logic [31:0] r;
      r = '0;
      case (a)
         3'd0: for (int i = 0; i < WIDTH; i++) r[i] = m_dir[i] ? m_out[i] : s[i];
         3'd1: r[WIDTH-1:0] = m_dir;
         3'd2: r[WIDTH-1:0] = m_mask;
         3'd3: r[WIDTH-1:0] = m_edge;
         default: r = '0;
      endcase
      return r;
   endfunction

   always @(posedge clk or negedge reset_n) begin : model
      logic [WIDTH-1:0] s, p, det, wdv;
      logic             wr_m, rd_m;
      if (!reset_n) begin
         m_out   = OUT_RESET;
         m_dir   = DIR_RESET;
         m_mask  = '0;
         m_edge  = '0;
         m_rdata = '0;
         for (int i = 0; i <= SYNC_STAGES; i++) m_hist[i] = '0;
      end else begin
         s    = m_hist[SYNC_STAGES-1];
         p    = m_hist[SYNC_STAGES];
         wr_m = bus.chipselect && !bus.write_n;
         rd_m = bus.chipselect && !bus.read_n;
         wdv  = bus.writedata[WIDTH-1:0];
         case (EDGE_TYPE)
            0:       det = s & ~p;
            1:       det = ~s & p;
            default: det = s ^ p;
         endcase
         if (rd_m) m_rdata = model_read(bus.address, s);
         if (wr_m) begin
            case (bus.address)
               3'd0: m_out  = wdv;
               3'd1: m_dir  = wdv;
               3'd2: m_mask = wdv;
               3'd3: m_edge = m_edge & ~wdv;
               3'd4: m_out  = m_out | wdv;
               3'd5: m_out  = m_out & ~wdv;
               default: ;
            endcase
         end
         m_edge = m_edge | det;
         for (int i = SYNC_STAGES; i > 0; i--) m_hist[i] = m_hist[i-1];
         m_hist[0] = in_port;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(posedge clk) begin
      #1;
      if (reset_n) begin
         check("out_port", 32'(out_port), 32'(m_out));
         check("oe_port", 32'(oe_port), 32'(m_dir));
         check("irq", 32'(irq), 32'(|(m_edge & m_mask)));
         check("readdata", bus.readdata, m_rdata);
      end
   end

   // ---------------- stimulus ----------------
   task automatic bus_idle();
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.read_n     = 1'b1;
      bus.address    = '0;
      bus.writedata  = '0;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      bus.read_n     = 1'b1;
      bus.address    = a;
      bus.writedata  = d;
      @(negedge clk);
      bus_idle();
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b1;
      bus.read_n     = 1'b0;
      bus.address    = a;
      @(negedge clk);
      d = bus.readdata;
      bus_idle();
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [31:0] rv;
      bus_idle();
      reset_n = 1'b0;
      wait_cycles(3);
      check("reset_readdata", bus.readdata, 32'h0);
      reset_n = 1'b1;
      wait_cycles(1);
      check("reset_out_port", 32'(out_port), 32'h3);
      check("reset_oe_port", 32'(oe_port), 32'hF);
      check("reset_irq", 32'(irq), 32'h0);
      bus_read(3'd0, rv);
      check("reset_read_data", rv, 32'h3);

      // Atomic set / clear / direct data write.
      bus_write(3'd4, 32'h8);
      check("outset", 32'(out_port), 32'hB);
      bus_write(3'd5, 32'h1);
      check("outclr", 32'(out_port), 32'hA);
      bus_write(3'd0, 32'h5);
      check("data_write", 32'(out_port), 32'h5);

      // Mixed direction readback.
      bus_write(3'd1, 32'hC);
      in_port = 4'h2;
      wait_cycles(3);
      bus_read(3'd0, rv);
      check("dir_readback", rv, 32'h6);

      // Rising edge capture and IRQ.
      bus_write(3'd3, 32'hF);
      bus_write(3'd2, 32'h1);
      in_port[0] = 1'b1;
      wait_cycles(2);
      check("irq_before_capture", 32'(irq), 32'h0);
      wait_cycles(1);
      check("irq_on_capture", 32'(irq), 32'h1);
      bus_write(3'd3, 32'h1);
      check("irq_after_clear", 32'(irq), 32'h0);
      in_port[0] = 1'b0;
      wait_cycles(5);
      check("falling_no_irq", 32'(irq), 32'h0);
      bus_read(3'd3, rv);
      check("falling_no_capture", rv, 32'h0);

      // Make bit 0 pending, then collide a clear with a new rising edge.
      in_port[0] = 1'b1;
      wait_cycles(4);
      in_port[0] = 1'b0;
      wait_cycles(4);
      check("pending_irq", 32'(irq), 32'h1);
      in_port[0] = 1'b1;
      wait_cycles(2);
      bus_write(3'd3, 32'h1);
      check("collision_irq", 32'(irq), 32'h1);
      bus_read(3'd3, rv);
      check("collision_edge", rv, 32'h1);

      // Randomised traffic.
      for (int n = 0; n < 2000; n++) begin
         int op;
         op = int'($urandom_range(0, 3));
         bus.chipselect = ($urandom_range(0, 7) != 0);
         bus.write_n    = !(op == 1 || op == 3);
         bus.read_n     = !(op == 2 || op == 3);
         bus.address    = 3'($urandom);
         bus.writedata  = $urandom;
         if ($urandom_range(0, 3) == 0) in_port = WIDTH'($urandom);
         @(negedge clk);
      end
      bus_idle();

      // Mid-operation asynchronous reset with all edges pending.
      in_port = '0;
      wait_cycles(4);
      bus_write(3'd3, 32'hF);
      bus_write(3'd2, 32'hF);
      in_port = 4'hF;
      wait_cycles(4);
      bus_read(3'd3, rv);
      check("pre_reset_edge", rv, 32'hF);
      check("pre_reset_irq", 32'(irq), 32'h1);
      in_port = '0;
      #2;
      reset_n = 1'b0;
      #1;
      check("async_irq", 32'(irq), 32'h0);
      check("async_readdata", bus.readdata, 32'h0);
      check("async_out_port", 32'(out_port), 32'h3);
      wait_cycles(2);
      reset_n = 1'b1;
      bus_read(3'd3, rv);
      check("post_reset_edge", rv, 32'h0);
      bus_read(3'd2, rv);
      check("post_reset_mask", rv, 32'h0);
      wait_cycles(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lms_ctr_gpio_bidir.md
Name: lms_ctr_gpio_bidir

Overview:
- Parametrised successor to the fixed 4-bit output-only control GPIO on the lms_ctr Avalon-MM bus.
- Adds configurable width, a per-bit direction register with output-enable, and synchronised inputs.
- Adds edge capture with per-bit interrupt mask and a level IRQ to the soft CPU.
- Keeps the atomic set/clear output registers at addresses 4/5.

Parameters:
- WIDTH, 4: number of GPIO bits; legal range 1..32.
- OUT_RESET, 3: reset value of the output data register; WIDTH bits.
- DIR_RESET, all ones: reset value of the direction register; 1 = output.
- EDGE_TYPE, 0: edge to capture; 0 = rising, 1 = falling, 2 = any.
- SYNC_STAGES, 2: input synchroniser depth; legal range 2..3.

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  Avalon word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- read_n  in  1  active-low read strobe.
- writedata  in  32  write data; bits above WIDTH-1 ignored.
- readdata  out  32  read data, registered; bits above WIDTH-1 read 0.
- in_port  in  WIDTH  asynchronous pin inputs.
- out_port  out  WIDTH  output data register.
- oe_port  out  WIDTH  output enable; equals the direction register.
- irq  out  1  level interrupt: OR of (edge_capture & irq_mask).

Behaviour:
- Reset: clock is clk; reset is asynchronous, active-low on reset_n. All state is cleared asynchronously.
  - out_port = OUT_RESET, oe_port = DIR_RESET.
  - irq_mask = 0, edge_capture = 0, readdata = 0, irq = 0.
  - Synchroniser and previous-sample flops = 0.
- Strobes:
  - wr = chipselect & ~write_n.
  - rd = chipselect & ~read_n.
- Register map (word address):
  - 0 DATA: write loads data_out. Read returns, per bit, data_out where dir = 1 and in_sync where dir = 0.
  - 1 DIR: read/write.
  - 2 IRQ_MASK: read/write.
  - 3 EDGE: read returns edge_capture. Write 1 clears the bit; write 0 has no effect.
  - 4 OUTSET: data_out |= wd. Reads 0.
  - 5 OUTCLR: data_out &= ~wd. Reads 0.
  - 6, 7: writes ignored, reads 0.
- Read latency: 1 cycle. readdata updates on the clock edge where rd = 1 and holds otherwise, for Avalon readLatency = 1. Read has no side effects.
- Input path:
  - in_port passes through SYNC_STAGES flops to give in_sync, then one further flop gives in_prev.
  - Edge detect: rise = in_sync & ~in_prev; fall = ~in_sync & in_prev; any = rise | fall, selected by EDGE_TYPE.
  - Edges are detected on every bit regardless of direction, so output pins are observable through loopback.
- Edge-capture bit set/clear rules:
  - A detected edge sets the bit.
  - A write-1-clear in the same cycle as a new edge on the same bit leaves the bit set; the edge wins.
- Latency from pin to capture bit: a pin change is in edge_capture SYNC_STAGES+1 cycles after it is first sampled. irq follows combinationally from registered state.
- Masking: changing irq_mask does not clear edge_capture. irq asserts as soon as the mask is set over a pending bit.
- Only one register address is accessed per cycle, so DATA/OUTSET/OUTCLR never conflict.
- Simultaneous wr and rd: both take effect. readdata returns the pre-write value.

Decomposition:
- Package lms_ctr_gpio_pkg:
  - Address constants: ADDR_DATA = 0, ADDR_DIR = 1, ADDR_MASK = 2, ADDR_EDGE = 3, ADDR_SET = 4, ADDR_CLR = 5.
  - EDGE_RISE = 0, EDGE_FALL = 1, EDGE_ANY = 2.
- Sub-module gpio_sync_edge:
  - Vector-wide synchroniser plus previous-sample register and edge detect.
  - Params WIDTH, SYNC_STAGES, EDGE_TYPE.
  - Outputs in_sync and an edge pulse vector.
- Top level holds the register file, read mux and IRQ.

Test Plan:
- Reset (WIDTH=4): release reset -> out_port = 4'h3, oe_port = 4'hF, irq = 0. Read addr 0 -> readdata = 0x3 one cycle after rd.
- Set/clear: write 0x8 to addr 4 -> out_port = 0xB. Write 0x1 to addr 5 -> out_port = 0xA. Write 0x5 to addr 0 -> out_port = 0x5.
- Direction/readback: write 0xC to addr 1, drive in_port = 0x2, data_out = 0x5 -> after sync, read addr 0 -> 0x6.
- Edge/IRQ (EDGE_TYPE=0): mask = 0x1, in_port[0] 0->1 -> edge bit 0 set 3 cycles later and irq = 1. Write 0x1 to addr 3 -> irq = 0 next cycle. A falling edge causes no capture.
- Clear-vs-edge collision: write 0x1 to addr 3 in the exact cycle a rising edge is detected on bit 0 -> edge_capture[0] stays 1, irq stays 1.
- Mid-operation reset: assert reset_n low with edge_capture = 0xF and irq = 1 -> irq = 0, edge_capture = 0 and readdata = 0 immediately, without waiting for clk.
